// File: rtl/booth_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_scheduler_if
// Description : Bundle between the voting booths / tally unit and the booth
//               scheduler.
//               Booth side : Close, req[3:0], cand[15:0]  -> scheduler
//               Scheduler  : ack, reject, Ballot, IN, busy, closed, issued
// Revision    : 1.0  initial release
// ============================================================================
interface booth_scheduler_if;
    logic        Close;   // polls-closed level
    logic [3:0]  req;     // per-booth request level
    logic [15:0] cand;    // per-booth candidate code, booth k on [4k+3:4k]
    logic [3:0]  ack;     // one-cycle vote-issued pulse
    logic [3:0]  reject;  // one-cycle request-dropped pulse
    logic        Ballot;  // ballot-open strobe to tally unit
    logic [3:0]  IN;      // candidate code to tally unit
    logic        busy;    // scheduler not idle
    logic        closed;  // scheduler in closed state
    logic [11:0] issued;  // votes issued since reset, modulo 4096

    // Scheduler side
    modport slave (
        input  Close, req, cand,
        output ack, reject, Ballot, IN, busy, closed, issued
    );

    // Booth / tally side
    modport master (
        output Close, req, cand,
        input  ack, reject, Ballot, IN, busy, closed, issued
    );
endinterface
`default_nettype wire

// File: rtl/booth_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : booth_scheduler
// Description : Round-robin scheduler granting four voting booths access to a
//               single tally unit. A grant runs ISSUE -> HOLD -> SETTLE; a
//               zero candidate code is rejected instead of issued.
// Ports       : clk    - system clock, rising edge active
//               rst_n  - synchronous active-low reset
//               bus    - booth_scheduler_if.slave (requests in, strobes out)
// Revision    : 1.0  initial release
// ============================================================================
module booth_scheduler (
    input  wire logic             clk,
    input  wire logic             rst_n,
    booth_scheduler_if.slave      bus
);

    localparam int c_NB = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_HOLD   = 3'd2,
        S_SETTLE = 3'd3,
        S_CLOSED = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_last;      // last booth granted (or rejected)
    logic [3:0]  r_cand_lat;  // candidate latched at grant
    logic        r_drop;      // current ISSUE cycle is a reject, not a vote
    logic [11:0] r_issued;
    logic [3:0]  r_ack;
    logic [3:0]  r_reject;
    logic        r_ballot;
    logic [3:0]  r_in;
    logic        r_busy;
    logic        r_closed;

    // ------------------------------------------------------------------
    // Round-robin winner: scan from r_last+1 upward, wrapping at 4.
    // ------------------------------------------------------------------
    logic        w_found;
    logic [1:0]  w_winner;
    logic [1:0]  w_idx;
    logic [3:0]  w_cand;
    logic [3:0]  w_onehot;

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        w_idx    = r_last;
        for (int i = 1; i <= c_NB; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_cand   = bus.cand[{w_winner, 2'b00} +: 4];
    assign w_onehot = 4'b0001 << w_winner;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs.
    // The IDLE decision is also taken on the way out of SETTLE so that a
    // pending request is granted without an extra idle cycle; this keeps
    // back-to-back Ballot strobes exactly three cycles apart. A Close seen
    // at that point still wins over any request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last     <= 2'd3;
            r_cand_lat <= 4'd0;
            r_drop     <= 1'b0;
            r_issued   <= 12'd0;
            r_ack      <= 4'd0;
            r_reject   <= 4'd0;
            r_ballot   <= 1'b0;
            r_in       <= 4'd0;
            r_busy     <= 1'b0;
            r_closed   <= 1'b0;
        end else begin
            r_ack    <= 4'd0;
            r_reject <= 4'd0;
            r_ballot <= 1'b0;

            case (r_state)
                S_IDLE, S_SETTLE: begin
                    r_in <= 4'd0;
                    if (bus.Close) begin
                        r_state  <= S_CLOSED;
                        r_closed <= 1'b1;
                        r_busy   <= 1'b1;
                    end else if (w_found) begin
                        r_state    <= S_ISSUE;
                        r_busy     <= 1'b1;
                        r_last     <= w_winner;
                        r_cand_lat <= w_cand;
                        if (w_cand == 4'd0) begin
                            // Invalid code: pulse reject, no ballot, back to IDLE
                            r_reject <= w_onehot;
                            r_drop   <= 1'b1;
                        end else begin
                            r_drop   <= 1'b0;
                            r_ack    <= w_onehot;
                            r_ballot <= 1'b1;
                            r_in     <= w_cand;
                            r_issued <= r_issued + 12'd1;  // wraps 4095 -> 0
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    if (r_drop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_drop  <= 1'b0;
                    end else begin
                        r_state <= S_HOLD;
                        r_in    <= r_cand_lat;
                    end
                end

                S_HOLD: begin
                    r_state <= S_SETTLE;
                    r_in    <= 4'd0;
                end

                S_CLOSED: begin
                    r_in <= 4'd0;
                    if (!bus.Close) begin
                        r_state  <= S_IDLE;
                        r_closed <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_in     <= 4'd0;
                    r_drop   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_closed <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack    = r_ack;
    assign bus.reject = r_reject;
    assign bus.Ballot = r_ballot;
    assign bus.IN     = r_in;
    assign bus.busy   = r_busy;
    assign bus.closed = r_closed;
    assign bus.issued = r_issued;

endmodule
`default_nettype wire

// File: tb/tb_booth_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_scheduler
// Description : Directed self-checking bench for booth_scheduler.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_booth_scheduler;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    booth_scheduler_if bus ();

    booth_scheduler u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; drive and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bus.Close = 1'b0;
        bus.req   = 4'h0;
        bus.cand  = 16'h0000;

        // ---------------- reset state ----------------
        tick();
        chk("rst_ballot", 32'(bus.Ballot), 32'd0);
        chk("rst_in",     32'(bus.IN),     32'd0);
        chk("rst_ack",    32'(bus.ack),    32'd0);
        chk("rst_reject", 32'(bus.reject), 32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_closed", 32'(bus.closed), 32'd0);
        chk("rst_issued", 32'(bus.issued), 32'd0);

        // ---------------- single vote, booth 0, code 5 ----------------
        rst_n    = 1'b1;
        bus.req  = 4'b0001;
        bus.cand = 16'h0005;
        tick();                                   // ISSUE
        chk("v1_ballot", 32'(bus.Ballot), 32'd1);
        chk("v1_in",     32'(bus.IN),     32'd5);
        chk("v1_ack",    32'(bus.ack),    32'h1);
        chk("v1_issued", 32'(bus.issued), 32'd1);
        chk("v1_busy",   32'(bus.busy),   32'd1);
        bus.req = 4'b0000;
        tick();                                   // HOLD
        chk("v1_hold_ballot", 32'(bus.Ballot), 32'd0);
        chk("v1_hold_in",     32'(bus.IN),     32'd5);
        chk("v1_hold_ack",    32'(bus.ack),    32'd0);
        tick();                                   // SETTLE
        chk("v1_settle_in",   32'(bus.IN),     32'd0);
        chk("v1_settle_busy", 32'(bus.busy),   32'd1);
        tick();                                   // IDLE
        chk("v1_idle_busy",   32'(bus.busy),   32'd0);
        chk("v1_idle_issued", 32'(bus.issued), 32'd1);

        // ---------------- contention from fresh reset ----------------
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        bus.req  = 4'b1111;
        bus.cand = 16'h3333;
        for (int n = 0; n < 5; n++) begin
            tick();                               // ISSUE
            chk("rr_ack",    32'(bus.ack),    32'(1 << (n % 4)));
            chk("rr_ballot", 32'(bus.Ballot), 32'd1);
            chk("rr_in",     32'(bus.IN),     32'd3);
            if (n < 4) begin
                tick();
                chk("rr_gap1", 32'(bus.Ballot), 32'd0);
                tick();
                chk("rr_gap2", 32'(bus.Ballot), 32'd0);
            end
        end
        chk("rr_issued", 32'(bus.issued), 32'd5);
        bus.req = 4'b0000;
        tick();                                   // HOLD
        tick();                                   // SETTLE
        tick();                                   // IDLE
        chk("rr_idle_busy", 32'(bus.busy), 32'd0);

        // ---------------- invalid code, booth 2 ----------------
        bus.req  = 4'b0100;
        bus.cand = 16'h3033;
        tick();
        chk("inv_reject", 32'(bus.reject), 32'h4);
        chk("inv_ballot", 32'(bus.Ballot), 32'd0);
        chk("inv_ack",    32'(bus.ack),    32'd0);
        bus.req = 4'b0000;
        tick();
        chk("inv_reject_clr", 32'(bus.reject), 32'd0);
        chk("inv_busy",       32'(bus.busy),   32'd0);
        chk("inv_issued",     32'(bus.issued), 32'd5);

        // ---------------- close mid-vote + cand latching ----------------
        bus.req  = 4'b0001;                       // last winner 2 -> booth 0 next
        bus.cand = 16'h0007;
        tick();                                   // ISSUE
        chk("cl_ack", 32'(bus.ack), 32'h1);
        chk("cl_in",  32'(bus.IN),  32'd7);
        bus.req  = 4'b0000;
        bus.cand = 16'h0009;
        tick();                                   // HOLD
        chk("cl_latch_in", 32'(bus.IN), 32'd7);
        bus.Close = 1'b1;
        tick();                                   // SETTLE
        chk("cl_settle_in",     32'(bus.IN),     32'd0);
        chk("cl_settle_closed", 32'(bus.closed), 32'd0);
        tick();                                   // CLOSED
        chk("cl_closed", 32'(bus.closed), 32'd1);
        chk("cl_busy",   32'(bus.busy),   32'd1);
        bus.req  = 4'b1111;
        bus.cand = 16'h3333;
        tick();
        chk("cl_noack",    32'(bus.ack),    32'd0);
        chk("cl_noballot", 32'(bus.Ballot), 32'd0);
        chk("cl_still",    32'(bus.closed), 32'd1);
        bus.Close = 1'b0;
        tick();                                   // IDLE
        chk("cl_open",      32'(bus.closed), 32'd0);
        chk("cl_open_busy", 32'(bus.busy),   32'd0);
        chk("cl_open_ack",  32'(bus.ack),    32'd0);
        tick();                                   // grant after last winner 0
        chk("cl_next_ack",    32'(bus.ack),    32'h2);
        chk("cl_next_issued", 32'(bus.issued), 32'd7);
        tick();
        tick();
        tick();                                   // ISSUE booth 2
        chk("rs_pre_ack", 32'(bus.ack), 32'h4);

        // ---------------- reset in ISSUE, Close asserted too ----------------
        rst_n     = 1'b0;
        bus.Close = 1'b1;
        tick();
        chk("rs_ballot", 32'(bus.Ballot), 32'd0);
        chk("rs_in",     32'(bus.IN),     32'd0);
        chk("rs_issued", 32'(bus.issued), 32'd0);
        chk("rs_busy",   32'(bus.busy),   32'd0);
        chk("rs_closed", 32'(bus.closed), 32'd0);
        chk("rs_ack",    32'(bus.ack),    32'd0);
        rst_n     = 1'b1;
        bus.Close = 1'b0;
        tick();                                   // fresh grant, booth 0
        chk("rs_fresh_ack",    32'(bus.ack),    32'h1);
        chk("rs_fresh_issued", 32'(bus.issued), 32'd1);
        bus.req = 4'b0000;
        tick();
        tick();
        tick();

        // ---------------- issued wraps 4095 -> 0 ----------------
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        bus.req  = 4'b0001;
        bus.cand = 16'h0001;
        tick();
        chk("wr_first", 32'(bus.issued), 32'd1);
        for (int k = 0; k < 3 * 4094; k++) tick();
        chk("wr_4095",        32'(bus.issued), 32'd4095);
        chk("wr_4095_ballot", 32'(bus.Ballot), 32'd1);
        tick();
        tick();
        tick();
        chk("wr_zero",        32'(bus.issued), 32'd0);
        chk("wr_zero_ballot", 32'(bus.Ballot), 32'd1);
        bus.req = 4'b0000;
        tick();
        tick();
        tick();
        chk("wr_idle_issued", 32'(bus.issued), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
